wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback requesters (req0: ALU path, req1: load/mult path).
//  Picks one request per cycle, round-robin, and drives wr_sel to the 5-bit destination-address mux and the data mux.
//  Registers the chosen write for the register file, which samples it on the next clock edge.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  DATA_W  32  width of write data
//  ADDR_W   5  width of register address (32 GPRs)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       synchronous reset, active-low
//  req0_valid   in   1       requester 0 has a write pending
//  req0_addr    in   ADDR_W  requester 0 destination register
//  req0_data    in   DATA_W  requester 0 write data
//  req0_ready   out  1       requester 0 write accepted this cycle (combinational)
//  req1_valid/req1_addr/req1_data/req1_ready    same as req0, for requester 1
//  wr_stall     in   1       register file cannot accept a write this cycle
//  wr_sel       out  1       mux select: 0 = req0 addr/data, 1 = req1 (combinational, matches grant)
//  wr_en        out  1       registered write enable to register file
//  wr_addr      out  ADDR_W  registered write address
//  wr_data      out  DATA_W  registered write data
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge): wr_en=0, wr_addr=0, wr_data=0, last_gnt=1 (req0 wins first tie), FSM=IDLE.
//    Reset mid-operation drops any registered, unwritten write. No request is accepted in a reset cycle.
//  - Handshake: reqN is accepted when reqN_valid && reqN_ready at the edge. reqN_ready is never high without reqN_valid.
//    A requester holds valid/addr/data stable until it is accepted.
//  - Grant, when wr_stall=0:
//    only req0 valid -> grant 0; only req1 valid -> grant 1; both valid -> grant !last_gnt. last_gnt updates on each grant.
//    wr_stall=1: no grant, both readys low, output registers hold their values.
//  - wr_sel = granted index. With no grant it holds its previous value, so the mux does not toggle.
//  - Latency: accept at edge k -> wr_en/addr/data valid during cycle k+1. Throughput is 1 write/cycle.
//  - wr_en=1 for exactly one cycle per accepted write, unless a stall holds it longer.
//    Without a new grant, wr_en returns to 0 on the next un-stalled edge.
//  - Register $0: a write to addr 0 is accepted (ready=1) but is registered with wr_en=0.
//  - FSM (state of the output stage):
//    IDLE -> WRITE on a grant. WRITE -> WRITE on a grant. WRITE -> IDLE with no grant and wr_stall=0.
//    WRITE -> HOLD on wr_stall=1. HOLD -> WRITE/IDLE when wr_stall falls, using the same rules.
//    IDLE with wr_stall=1 stays in IDLE.
//  - Fairness: a continuously valid requester is granted within 2 un-stalled cycles.
//  - Same-address writes from both requesters in consecutive cycles are written in grant order (last write wins).
//    The arbiter does no hazard merging.
// CONFIGURATION
//  WB_ARB_STATS_EN defined: adds outputs gnt0_cnt and gnt1_cnt, each 16 bits.
//    Each is a free-running count of accepted writes, wraps 0xFFFF->0, and is cleared by rst_n.
//    It counts addr-0 accepts too.
//  WB_ARB_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package wb_arb_pkg: ADDR_W/DATA_W defaults, ZERO_REG=5'd0, FSM state encoding (IDLE=2'd0, WRITE=2'd1, HOLD=2'd2).
//  Sub-module rr_arb2: 2-way round-robin grant logic with inputs req[1:0], last_gnt, en.
//    Outputs are gnt[1:0] (one-hot or zero) and gnt_idx.
//  Top level: output registers, FSM, $0 filter, optional stats counters.
// TESTING
//  1. Reset: hold rst_n=0 with both valid -> wr_en=0, both readys=0. First cycle after release, both valid -> req0 granted.
//  2. Only req1 valid, addr=5'd7, data=32'hDEAD_BEEF -> req1_ready=1, wr_sel=1.
//     Next cycle: wr_en=1, wr_addr=7, wr_data=DEADBEEF.
//  3. Both valid for 4 cycles -> grants 0,1,0,1. Each requester gets 2 writes. wr_en stays high for 4 consecutive cycles.
//  4. req0 valid, addr=0 -> req0_ready=1. Next cycle wr_en=0.
//  5. wr_stall=1 for 3 cycles with a write registered -> outputs held, both readys 0, FSM=HOLD.
//     When the stall drops, the held write completes and the pending request is then granted.
//  6. WB_ARB_STATS_EN: 10 req0 and 5 req1 accepts -> gnt0_cnt=10, gnt1_cnt=5. Reset clears both to 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, the $0 register address and output-stage state encoding for wb_port_arbiter.
package wb_arb_pkg;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam logic [4:0] ZERO_REG = 5'd0;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } state_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: two writeback requesters plus the register-file write port.
interface wb_port_arbiter_if
   import wb_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              wr_stall;
   logic              wr_sel;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, wr_stall,
      input  req0_ready, req1_ready, wr_sel, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, wr_stall,
      output req0_ready, req1_ready, wr_sel, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/wb_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester not granted last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_idx
);
   assign gnt[0]  = en & req[0] & (~req[1] | last_gnt);
   assign gnt[1]  = en & req[1] & (~req[0] | ~last_gnt);
   assign gnt_idx = gnt[1];
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin share of the register-file write port between two writeback paths.
// Define WB_ARB_STATS_EN to add the gnt0_cnt/gnt1_cnt accepted-write counters.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
)
(
   input  logic clk,
   input  logic rst_n,
`ifdef WB_ARB_STATS_EN
   output logic [15:0] gnt0_cnt,
   output logic [15:0] gnt1_cnt,
`endif
   wb_port_arbiter_if.slave bus
);
   logic [1:0]        gnt;
   logic              gnt_idx;
   logic              any_gnt;
   logic              last_gnt;
   logic              sel_q;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   state_t            state;
   state_t            state_nxt;

   rr_arb2 u_rr (
      .req      ({bus.req1_valid, bus.req0_valid}),
      .last_gnt (last_gnt),
      .en       (rst_n & ~bus.wr_stall),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx)
   );

   assign any_gnt        = |gnt;
   assign bus.req0_ready = gnt[0];
   assign bus.req1_ready = gnt[1];
   // Hold the previous select when idle so the address/data muxes stay quiet.
   assign bus.wr_sel     = any_gnt ? gnt_idx : sel_q;
   assign sel_addr       = gnt_idx ? bus.req1_addr : bus.req0_addr;
   assign sel_data       = gnt_idx ? bus.req1_data : bus.req0_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         last_gnt    <= 1'b1;
         sel_q       <= 1'b0;
      end else if (any_gnt) begin
         bus.wr_en   <= sel_addr != ADDR_W'(ZERO_REG);
         bus.wr_addr <= sel_addr;
         bus.wr_data <= sel_data;
         last_gnt    <= gnt_idx;
         sel_q       <= gnt_idx;
      end else if (!bus.wr_stall) begin
         bus.wr_en   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      state_nxt = any_gnt ? WRITE : !bus.wr_stall ? IDLE : (state == IDLE) ? IDLE : HOLD;
   end

`ifdef WB_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt0_cnt <= '0;
         gnt1_cnt <= '0;
      end else begin
         gnt0_cnt <= gnt0_cnt + 16'(gnt[0]);
         gnt1_cnt <= gnt1_cnt + 16'(gnt[1]);
      end
   end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors with hand-computed expectations for wb_port_arbiter.
module tb_wb_port_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_pass = 0;
   int   n_total = 0;
`ifdef WB_ARB_STATS_EN
   logic [15:0] gnt0_cnt;
   logic [15:0] gnt1_cnt;
`endif

   wb_port_arbiter_if bus ();

   wb_port_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef WB_ARB_STATS_EN
      .gnt0_cnt (gnt0_cnt),
      .gnt1_cnt (gnt1_cnt),
`endif
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] st();
      return logic'(dut.state[1]) ? 2'd2 : {1'b0, dut.state[0]};
   endfunction

   initial begin
      rst_n          = 1'b0;
      bus.wr_stall   = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'd1;
      bus.req0_data  = 32'h1111_0001;
      bus.req1_valid = 1'b1;
      bus.req1_addr  = 5'd2;
      bus.req1_data  = 32'h2222_0002;
      step();
      step();
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_state", st(), 0);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_sel", bus.wr_sel, i % 2);
         chk("rr_ready0", bus.req0_ready, (i % 2) == 0);
         chk("rr_ready1", bus.req1_ready, (i % 2) == 1);
         step();
         chk("rr_wr_en", bus.wr_en, 1);
         chk("rr_wr_addr", bus.wr_addr, (i % 2) ? 2 : 1);
         chk("rr_state", st(), 1);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      step();
      chk("drain_wr_en", bus.wr_en, 0);
      chk("drain_state", st(), 0);
      bus.req1_valid = 1'b1;
      bus.req1_addr  = 5'd7;
      bus.req1_data  = 32'hDEAD_BEEF;
      #1;
      chk("r1_ready1", bus.req1_ready, 1);
      chk("r1_ready0", bus.req0_ready, 0);
      chk("r1_sel", bus.wr_sel, 1);
      step();
      chk("r1_wr_en", bus.wr_en, 1);
      chk("r1_wr_addr", bus.wr_addr, 7);
      chk("r1_wr_data", bus.wr_data, 32'hDEAD_BEEF);
      bus.req1_valid = 1'b0;
      #1;
      chk("sel_hold1", bus.wr_sel, 1);
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'd0;
      bus.req0_data  = 32'hCAFE_0000;
      #1;
      chk("z_ready0", bus.req0_ready, 1);
      chk("z_sel", bus.wr_sel, 0);
      step();
      chk("z_wr_en", bus.wr_en, 0);
      bus.req0_addr = 5'd3;
      bus.req0_data = 32'h3333_3333;
      step();
      chk("s_wr_en", bus.wr_en, 1);
      chk("s_wr_addr", bus.wr_addr, 3);
      bus.req0_valid = 1'b0;
      bus.wr_stall   = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req1_addr  = 5'd9;
      bus.req1_data  = 32'h9999_9999;
      #1;
      chk("s_ready0", bus.req0_ready, 0);
      chk("s_ready1", bus.req1_ready, 0);
      chk("s_sel_hold", bus.wr_sel, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s_hold_en", bus.wr_en, 1);
         chk("s_hold_addr", bus.wr_addr, 3);
         chk("s_hold_data", bus.wr_data, 32'h3333_3333);
         chk("s_state", st(), 2);
         chk("s_ready1", bus.req1_ready, 0);
      end
      bus.wr_stall = 1'b0;
      #1;
      chk("u_ready1", bus.req1_ready, 1);
      step();
      chk("u_wr_en", bus.wr_en, 1);
      chk("u_wr_addr", bus.wr_addr, 9);
      chk("u_wr_data", bus.wr_data, 32'h9999_9999);
      chk("u_state", st(), 1);
      bus.req1_valid = 1'b0;
      step();
      chk("u_drain_en", bus.wr_en, 0);
      chk("u_drain_state", st(), 0);
      bus.wr_stall   = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'd4;
      #1;
      chk("is_ready0", bus.req0_ready, 0);
      step();
      chk("is_state", st(), 0);
      chk("is_wr_en", bus.wr_en, 0);
      bus.wr_stall = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("c0_wr_addr", bus.wr_addr, 4);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1;
      bus.req1_addr  = 5'd10;
      step();
      bus.req1_valid = 1'b0;
      step();
`ifdef WB_ARB_STATS_EN
      chk("cnt0", gnt0_cnt, 10);
      chk("cnt1", gnt1_cnt, 5);
`endif
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'd5;
      step();
      chk("mr_wr_en", bus.wr_en, 1);
      bus.req0_valid = 1'b0;
      rst_n = 1'b0;
      step();
      chk("mr_wr_en_drop", bus.wr_en, 0);
      chk("mr_wr_addr", bus.wr_addr, 0);
`ifdef WB_ARB_STATS_EN
      chk("cnt0_rst", gnt0_cnt, 0);
      chk("cnt1_rst", gnt1_cnt, 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
